// File: rtl/mem_port_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner codes and
// stall-bus bit positions. Optional counters are enabled by MEM_ARB_PERF_CNT_EN.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_WAIT = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_INST = 1'b0,
    ARB_OWN_DATA = 1'b1
  } arb_owner_e;

  // Bit positions of the two requests on the pipeline stall bus.
  localparam int unsigned STALL_BIT_IF  = 32'd1;
  localparam int unsigned STALL_BIT_MEM = 32'd3;

  localparam int unsigned PERF_CNT_W = 32'd32;

endpackage

// File: rtl/mem_arb_perf.sv
// Completion and wait-cycle counters for the arbiter; only instantiated when
// MEM_ARB_PERF_CNT_EN is defined. All counters wrap.
module mem_arb_perf
  import mem_port_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_inst,
  input  logic                  inc_data,
  input  logic                  inc_wait,
  output logic [PERF_CNT_W-1:0] perf_inst_cnt,
  output logic [PERF_CNT_W-1:0] perf_data_cnt,
  output logic [PERF_CNT_W-1:0] perf_wait_cnt
);

  logic [PERF_CNT_W-1:0] inst_cnt_r;
  logic [PERF_CNT_W-1:0] data_cnt_r;
  logic [PERF_CNT_W-1:0] wait_cnt_r;

  // Event counters, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt_r <= 32'd0;
      data_cnt_r <= 32'd0;
      wait_cnt_r <= 32'd0;
    end else begin
      if (inc_inst) inst_cnt_r <= inst_cnt_r + 32'd1;
      if (inc_data) data_cnt_r <= data_cnt_r + 32'd1;
      if (inc_wait) wait_cnt_r <= wait_cnt_r + 32'd1;
    end
  end

  assign perf_inst_cnt = inst_cnt_r;
  assign perf_data_cnt = data_cnt_r;
  assign perf_wait_cnt = wait_cnt_r;

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates one SRAM-like port between instruction fetch and data access.
// Define MEM_ARB_PERF_CNT_EN to add the perf_* counter outputs.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_valid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_valid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]         perf_inst_cnt,
  output logic [31:0]         perf_data_cnt,
  output logic [31:0]         perf_wait_cnt,
`endif
  output logic                stallreq_if,
  output logic                stallreq_mem
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_r, state_s;
  arb_owner_e          owner_r, grant_owner_s;
  logic                grant_s;
  logic                capture_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                inst_valid_r, data_valid_r;
  logic [DATA_W-1:0]   inst_rdata_r, data_rdata_r;

  // Next-state logic; data wins arbitration because MEM holds the older instruction.
  always_comb begin
    state_s       = state_r;
    grant_s       = 1'b0;
    grant_owner_s = ARB_OWN_INST;
    capture_s     = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (data_req) begin
          grant_s       = 1'b1;
          grant_owner_s = ARB_OWN_DATA;
          state_s       = ARB_REQ;
        end else if (inst_req) begin
          grant_s       = 1'b1;
          grant_owner_s = ARB_OWN_INST;
          state_s       = ARB_REQ;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (mem_addr_ok && mem_data_ok) begin
          capture_s = 1'b1;
          state_s   = ARB_DONE;
        end else if (mem_addr_ok) begin
          state_s = ARB_WAIT;
        end else begin
          state_s = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (mem_data_ok) begin
          capture_s = 1'b1;
          state_s   = ARB_DONE;
        end else begin
          state_s = ARB_WAIT;
        end
      end
      ARB_DONE: state_s = ARB_IDLE;
      default:  state_s = ARB_IDLE;
    endcase
  end

  // State, request latches, completion pulses and per-owner read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ARB_IDLE;
      owner_r      <= ARB_OWN_INST;
      addr_r       <= '0;
      wdata_r      <= '0;
      wstrb_r      <= '0;
      inst_valid_r <= 1'b0;
      data_valid_r <= 1'b0;
      inst_rdata_r <= '0;
      data_rdata_r <= '0;
    end else begin
      state_r      <= state_s;
      inst_valid_r <= capture_s && (owner_r == ARB_OWN_INST);
      data_valid_r <= capture_s && (owner_r == ARB_OWN_DATA);
      if (grant_s) begin
        owner_r <= grant_owner_s;
        if (grant_owner_s == ARB_OWN_DATA) begin
          addr_r  <= data_addr;
          wdata_r <= data_wdata;
          wstrb_r <= data_wen;
        end else begin
          addr_r  <= inst_addr;
          wdata_r <= '0;
          wstrb_r <= '0;
        end
      end
      if (capture_s && (owner_r == ARB_OWN_INST)) inst_rdata_r <= mem_rdata;
      // Writes leave the data-side read register untouched.
      if (capture_s && (owner_r == ARB_OWN_DATA) && (wstrb_r == '0)) data_rdata_r <= mem_rdata;
    end
  end

  assign mem_req    = (state_r == ARB_REQ);
  assign mem_wr     = |wstrb_r;
  assign mem_wstrb  = wstrb_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign inst_valid = inst_valid_r;
  assign data_valid = data_valid_r;
  assign inst_rdata = inst_rdata_r;
  assign data_rdata = data_rdata_r;

  // Gated by reset so every output is low while reset is held.
  assign stallreq_if  = rst & inst_req & ~inst_valid_r;
  assign stallreq_mem = rst & data_req & ~data_valid_r;

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .inc_inst      (inst_valid_r),
    .inc_data      (data_valid_r),
    .inc_wait      ((state_r == ARB_REQ) || (state_r == ARB_WAIT)),
    .perf_inst_cnt (perf_inst_cnt),
    .perf_data_cnt (perf_data_cnt),
    .perf_wait_cnt (perf_wait_cnt)
  );
`endif

endmodule
